// File: rtl/rol_5bit_seq.sv
// ---------------------------------------------------------------------------
// rol_5bit_seq
//   Sequential rotate-left unit for the execute stage. It rotates the operand
//   left by one bit per clock under a start/busy/done handshake. The result is
//   published in z together with carry, sign and zero flags.
//   The rotate amount is used literally and is not reduced modulo WIDTH, so
//   shift == WIDTH returns the operand unchanged after WIDTH+1 cycles.
//   z and the flags change only on the edge that enters DONE. They hold their
//   value between operations, so a partial rotation is never visible.
// ---------------------------------------------------------------------------
module rol_5bit_seq #(
  parameter int WIDTH = 5,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shift,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cf,
  output logic             sf,
  output logic             zf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [SHW-1:0]   CNT_ZERO  = {SHW{1'b0}};
  localparam logic [SHW-1:0]   CNT_ONE   = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  // Rotate left by one position: the MSB wraps around into the LSB.
  function automatic logic [WIDTH-1:0] rol1(input logic [WIDTH-1:0] v);
    rol1 = {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  // Zero flag of a result word.
  function automatic logic zero_flag(input logic [WIDTH-1:0] v);
    zero_flag = (v == DATA_ZERO);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [SHW-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0] z_q,     z_d;
  logic             cf_q,    cf_d;
  logic             sf_q,    sf_d;
  logic             zf_q,    zf_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] rot_s;

  // One-step rotation of the working register, used while in ROT.
  always_comb begin
    rot_s = rol1(work_q);
  end

  // Next-state, datapath and result/flag update logic.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    cf_d    = cf_q;
    sf_d    = sf_q;
    zf_d    = zf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d = a;
          cnt_d  = shift;
          if (shift == CNT_ZERO) begin
            // Nothing to rotate: publish the operand itself, carry is zero.
            state_d = S_DONE;
            z_d     = a;
            cf_d    = 1'b0;
            sf_d    = a[WIDTH-1];
            zf_d    = zero_flag(a);
          end else begin
            state_d = S_ROT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ROT: begin
        work_d = rot_s;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          // Final rotation: the bit that just left the MSB sits in r[0].
          state_d = S_DONE;
          z_d     = rot_s;
          cf_d    = rot_s[0];
          sf_d    = rot_s[WIDTH-1];
          zf_d    = zero_flag(rot_s);
        end else begin
          state_d = S_ROT;
        end
      end

      S_DONE: begin
        // start is ignored here; a new request is only seen back in IDLE.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs are registered from the state being entered.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, working registers and registered outputs; async reset clears all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= DATA_ZERO;
      cnt_q   <= CNT_ZERO;
      z_q     <= DATA_ZERO;
      cf_q    <= 1'b0;
      sf_q    <= 1'b0;
      zf_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      cf_q    <= cf_d;
      sf_q    <= sf_d;
      zf_q    <= zf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign z    = z_q;
  assign cf   = cf_q;
  assign sf   = sf_q;
  assign zf   = zf_q;

endmodule

// File: tb/tb_rol_5bit_seq.sv
// ---------------------------------------------------------------------------
// tb_rol_5bit_seq
//   Table-driven bench for the sequential rotate-left unit. Each operation
//   pushes its expected result to a scoreboard queue. A monitor pops and
//   compares that result when done is seen. Latency, busy length, result hold
//   during rotation, start-held and mid-rotation reset are also checked.
// ---------------------------------------------------------------------------
module tb_rol_5bit_seq;

  typedef struct {
    logic [4:0] a;
    logic [2:0] sh;
    logic [4:0] z;
    logic       cf;
    logic       sf;
    logic       zf;
    int         lat;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] a;
  logic [2:0] shift;
  logic       busy;
  logic       done;
  logic [4:0] z;
  logic       cf;
  logic       sf;
  logic       zf;

  int   total;
  int   passed;
  vec_t sb_q[$];
  vec_t tbl[11];
  logic [4:0] last_z;

  rol_5bit_seq #(.WIDTH(5), .SHW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .shift (shift),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .cf    (cf),
    .sf    (sf),
    .zf    (zf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("sb_pending", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        vec_t e;
        e = sb_q.pop_front();
        chk("z",  z,  e.z);
        chk("cf", cf, e.cf);
        chk("sf", sf, e.sf);
        chk("zf", zf, e.zf);
      end
    end
  end

  // One complete operation with latency, busy-length and result-hold checks.
  task automatic run_op(input vec_t v);
    int cycles;
    int busy_cnt;
    bit got;
    sb_q.push_back(v);
    @(negedge clk);
    a     = v.a;
    shift = v.sh;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 5'($urandom);
    shift = 3'($urandom);
    cycles   = 0;
    busy_cnt = 0;
    got      = 1'b0;
    while (!got && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
      end else begin
        chk("z_hold", z, last_z);
      end
    end
    chk("done_seen", got, 1);
    chk("latency", cycles, v.lat);
    chk("busy_len", busy_cnt, v.lat);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    last_z = v.z;
  endtask

  initial begin
    vec_t rv;
    logic [1:0] exp_busy[6];
    logic [1:0] exp_done[6];

    tbl[0]  = '{5'b11100, 3'b001, 5'b11001, 1'b1, 1'b1, 1'b0, 2};
    tbl[1]  = '{5'b11100, 3'b011, 5'b00111, 1'b1, 1'b0, 1'b0, 4};
    tbl[2]  = '{5'b11100, 3'b000, 5'b11100, 1'b0, 1'b1, 1'b0, 1};
    tbl[3]  = '{5'b11100, 3'b101, 5'b11100, 1'b0, 1'b1, 1'b0, 6};
    tbl[4]  = '{5'b11100, 3'b111, 5'b10011, 1'b1, 1'b1, 1'b0, 8};
    tbl[5]  = '{5'b00000, 3'b011, 5'b00000, 1'b0, 1'b0, 1'b1, 4};
    tbl[6]  = '{5'b10000, 3'b001, 5'b00001, 1'b1, 1'b0, 1'b0, 2};
    tbl[7]  = '{5'b01111, 3'b100, 5'b10111, 1'b1, 1'b1, 1'b0, 5};
    tbl[8]  = '{5'b00001, 3'b110, 5'b00010, 1'b0, 1'b0, 1'b0, 7};
    tbl[9]  = '{5'b11111, 3'b000, 5'b11111, 1'b0, 1'b1, 1'b0, 1};
    tbl[10] = '{5'b10101, 3'b010, 5'b10110, 1'b0, 1'b1, 1'b0, 3};

    total  = 0;
    passed = 0;
    last_z = 5'b00000;
    clk    = 1'b0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = 5'b00000;
    shift  = 3'b000;

    // Reset state.
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_z", z, 5'b00000);
    chk("rst_flags", {cf, sf, zf}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i]);
    end

    // start held high: second op accepted on the first IDLE edge after done.
    exp_busy = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0};
    exp_done = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0};
    sb_q.push_back(tbl[0]);
    sb_q.push_back(tbl[0]);
    @(negedge clk);
    a     = 5'b11100;
    shift = 3'b001;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("hold_busy", busy, exp_busy[k]);
      chk("hold_done", done, exp_done[k]);
      if (k == 4) start = 1'b0;
    end
    chk("hold_sb_empty", sb_q.size(), 0);
    last_z = 5'b11001;

    // Reset in the middle of a long rotation.
    sb_q.push_back(tbl[4]);
    @(negedge clk);
    a     = 5'b11100;
    shift = 3'b111;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_z", z, 5'b00000);
    chk("mid_rst_flags", {cf, sf, zf}, 3'b000);
    sb_q.delete();
    last_z = 5'b00000;
    @(negedge clk);
    rst_n = 1'b1;

    // Operation after reset release.
    rv = '{5'b10110, 3'b010, 5'b11010, 1'b0, 1'b1, 1'b0, 3};
    run_op(rv);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
